// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer: valid/ready word load, per-word bit order,
// ser_en pacing, and gapless chaining into the next word on the final bit.
module piso_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_rev;
  logic [WIDTH-1:0]   load_word;
  logic               accept;

  // The register always shifts out of its MSB, so LSB-first words load reversed.
  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign data_rev[g] = in_data[WIDTH-1-g];
  end
  assign load_word = in_msb_first ? in_data : data_rev;

  // Status decode from registered state only.
  assign ser_valid = (state_q == SHIFT);
  assign ser_last  = ser_valid && (cnt_q == '0);
  assign ser_out   = ser_valid && sreg_q[WIDTH-1];
  assign busy      = ser_valid;
  assign in_ready  = (state_q == IDLE) || (ser_last && ser_en);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sreg_d  = load_word;
          cnt_d   = CNT_W'(WIDTH - 1);
        end
      end
      SHIFT: begin
        if (ser_en) begin
          if (cnt_q != '0) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q - CNT_W'(1);
          end else if (accept) begin
            // Final bit consumed and a new word is waiting: chain with no gap.
            sreg_d = load_word;
            cnt_d  = CNT_W'(WIDTH - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream: a bit-queue reference model checked every
// cycle, plus directed sequences with literal expected bit patterns.
module tb_piso_stream;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_msb_first;
  logic             ser_en;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // Remaining bits of the words in flight, front = bit now on ser_out.
  bit model_q[$];

  piso_stream #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .ser_en       (ser_en),
    .ser_out      (ser_out),
    .ser_valid    (ser_valid),
    .ser_last     (ser_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance the model at posedge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic m, input logic e,
                      output logic so, output logic sl, output logic sv, output logic rdy);
    logic exp_valid, exp_out, exp_last, exp_ready, acc;
    in_valid     = v;
    in_data      = d;
    in_msb_first = m;
    ser_en       = e;
    #1;
    exp_valid = (model_q.size() > 0);
    exp_out   = exp_valid ? model_q[0] : 1'b0;
    exp_last  = (model_q.size() == 1);
    exp_ready = (model_q.size() == 0) || ((model_q.size() == 1) && e);
    check("ser_valid", 32'(ser_valid), 32'(exp_valid));
    check("ser_out",   32'(ser_out),   32'(exp_out));
    check("ser_last",  32'(ser_last),  32'(exp_last));
    check("busy",      32'(busy),      32'(exp_valid));
    check("in_ready",  32'(in_ready),  32'(exp_ready));
    so  = ser_out;
    sl  = ser_last;
    sv  = ser_valid;
    rdy = in_ready;
    acc = v && exp_ready && !rst;
    @(posedge clk);
    if (!rst) begin
      if (e && model_q.size() > 0) void'(model_q.pop_front());
      if (acc) begin
        for (int j = 0; j < int'(WIDTH); j++)
          model_q.push_back(d[m ? (int'(WIDTH) - 1 - j) : j]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic so, sl, sv, rdy;
    logic [WIDTH-1:0]   vec;
    logic [2*WIDTH-1:0] vec2, lastv;
    int nlast, nready, nvalid, k;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b1; ser_en = 1'b0;
    @(negedge clk);

    // Reset held for two cycles.
    for (int i = 0; i < 2; i++) step(1'b0, 8'hB4, 1'b1, 1'b1, so, sl, sv, rdy);
    rst = 1'b0;

    // MSB-first, offered on the first edge after release.
    step(1'b1, 8'hB4, 1'b1, 1'b1, so, sl, sv, rdy);
    nlast = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, so, sl, sv, rdy);
      vec[7-i] = so;
      if (sl) nlast++;
      if (i == 7) check("msb_last_on_8th", 32'(sl), 32'd1);
    end
    check("msb_bits", 32'(vec), 32'hB4);
    check("msb_last_count", 32'(nlast), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, so, sl, sv, rdy);
    check("msb_idle_after", 32'(sv), 32'd0);

    // LSB-first.
    step(1'b1, 8'hB4, 1'b0, 1'b1, so, sl, sv, rdy);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1, so, sl, sv, rdy);
      vec[7-i] = so;
    end
    check("lsb_bits", 32'(vec), 32'h2D);

    // Pacing: ser_en every third cycle.
    step(1'b1, 8'hB4, 1'b1, 1'b0, so, sl, sv, rdy);
    nready = 0; nvalid = 0; k = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 8'h00, 1'b1, (i % 3) == 2, so, sl, sv, rdy);
      if (sv) nvalid++;
      if (rdy) nready++;
      if ((i % 3) == 2) begin
        vec[7-k] = so;
        k++;
      end
    end
    check("pace_bits", 32'(vec), 32'hB4);
    check("pace_span", 32'(nvalid), 32'd24);
    check("pace_ready_count", 32'(nready), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, so, sl, sv, rdy);
    check("pace_idle_after", 32'(sv), 32'd0);

    // Back-to-back FF then 00 with in_data churn during the first word.
    step(1'b1, 8'hFF, 1'b1, 1'b1, so, sl, sv, rdy);
    nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 7)       step(1'b1, 8'($urandom), 1'($urandom), 1'b1, so, sl, sv, rdy);
      else if (i == 7) step(1'b1, 8'h00, 1'b1, 1'b1, so, sl, sv, rdy);
      else             step(1'b0, 8'h5A, 1'b1, 1'b1, so, sl, sv, rdy);
      vec2[15-i]  = so;
      lastv[15-i] = sl;
      if (sv) nvalid++;
    end
    check("b2b_bits", 32'(vec2), 32'hFF00);
    check("b2b_last", 32'(lastv), 32'h0101);
    check("b2b_contiguous", 32'(nvalid), 32'd16);

    // Asynchronous reset after the third bit.
    step(1'b1, 8'hB4, 1'b1, 1'b1, so, sl, sv, rdy);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1, so, sl, sv, rdy);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(ser_valid), 32'd0);
    check("rst_mid_out",   32'(ser_out),   32'd0);
    check("rst_mid_last",  32'(ser_last),  32'd0);
    check("rst_mid_busy",  32'(busy),      32'd0);
    check("rst_mid_ready", 32'(in_ready),  32'd1);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h81, 1'b1, 1'b1, so, sl, sv, rdy);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1, so, sl, sv, rdy);
      vec[7-i] = so;
    end
    check("post_rst_bits", 32'(vec), 32'h81);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
           so, sl, sv, rdy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
